// File: rtl/shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_pipe_pkg
// Purpose : Shared definitions for the shift_pipe block. Holds the operation
//           encoding, the FSM state encoding, the barrel shifter control
//           constants, and a helper that tells legal opcodes from illegal ones.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package shift_pipe_pkg;

   // Operation codes carried on in_op; codes 5..7 are illegal.
   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } op_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MASK = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Barrel shifter control values: shift_rotate=1 selects rotate,
   // left_right=1 selects a right-hand move.
   localparam logic SR_ROTATE = 1'b1;
   localparam logic SR_SHIFT  = 1'b0;
   localparam logic LR_RIGHT  = 1'b1;
   localparam logic LR_LEFT   = 1'b0;

   // True for the five defined opcodes.
   function automatic logic op_is_legal(input logic [2:0] op);
      logic legal;
      case (op)
         OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: legal = 1'b1;
         default:                                legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage : shift_pipe_pkg

// File: rtl/shift_pipe_barrel_shifter.sv
// -----------------------------------------------------------------------------
// shift_pipe_barrel_shifter
// Purpose : Purely combinational barrel shifter: logical shift or rotate,
//           left or right, by 0..WIDTH-1 positions.
// Ports   : data_i         - operand
//           amt_i          - shift / rotate count
//           shift_rotate_i - 1 = rotate, 0 = logical shift
//           left_right_i   - 1 = right,  0 = left
//           data_o         - result
// -----------------------------------------------------------------------------
module shift_pipe_barrel_shifter
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int SHFT_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]      data_i,
   input  logic [SHFT_WIDTH-1:0] amt_i,
   input  logic                  shift_rotate_i,
   input  logic                  left_right_i,
   output logic [WIDTH-1:0]      data_o
);

   // Rotates come out of a doubled operand: the bits shifted off one copy
   // land in the other, so one half of the doubled word is the rotation.
   logic [2*WIDTH-1:0] dbl_s;
   logic [2*WIDTH-1:0] dbl_left_s;
   logic [2*WIDTH-1:0] dbl_right_s;

   // Build the doubled operand and both of its shifted forms.
   always_comb begin
      dbl_s       = {data_i, data_i};
      dbl_left_s  = dbl_s << amt_i;
      dbl_right_s = dbl_s >> amt_i;
   end

   // Select the requested operation.
   always_comb begin
      case ({shift_rotate_i, left_right_i})
         {SR_ROTATE, LR_LEFT}:  data_o = dbl_left_s[2*WIDTH-1:WIDTH];
         {SR_ROTATE, LR_RIGHT}: data_o = dbl_right_s[WIDTH-1:0];
         {SR_SHIFT,  LR_RIGHT}: data_o = data_i >> amt_i;
         {SR_SHIFT,  LR_LEFT}:  data_o = data_i << amt_i;
         default:               data_o = data_i << amt_i;
      endcase
   end

endmodule : shift_pipe_barrel_shifter

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Purpose : Valid/ready wrapped shift/rotate unit. A command is captured in
//           IDLE (or in DONE while the previous result is consumed), executed
//           through one shared barrel shifter in EXEC, sign-extended in an
//           extra MASK pass for arithmetic right shifts, and presented in DONE.
// Ports   : clk, rst                       - clock, synchronous active-high reset
//           in_valid/in_ready               - command handshake
//           in_data, in_amt, in_op          - operand, count, opcode
//           out_valid/out_ready             - result handshake
//           out_data, out_err               - result, illegal-op flag
// -----------------------------------------------------------------------------
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int SHFT_WIDTH = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SHFT_WIDTH-1:0] in_amt,
   input  logic [2:0]            in_op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_err
);

   state_e                state_q,  state_d;
   logic [WIDTH-1:0]      opnd_q,   opnd_d;
   logic [SHFT_WIDTH-1:0] amt_q,    amt_d;
   logic [2:0]            op_q,     op_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic                  err_q,    err_d;

   logic                  accept_s;
   logic [WIDTH-1:0]      sh_data_s;
   logic                  sh_rotate_s;
   logic                  sh_right_s;
   logic [WIDTH-1:0]      sh_out_s;

   // Handshake decode; in DONE a new command may enter as the result leaves.
   always_comb begin
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_DONE: in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      accept_s  = in_valid && in_ready;
      out_valid = (state_q == ST_DONE);
      out_data  = result_q;
      out_err   = err_q;
   end

   // Shifter input mux: MASK reuses the shifter to build the sign-fill mask
   // by shifting all-ones logically right by the captured amount.
   always_comb begin
      if (state_q == ST_MASK) begin
         sh_data_s   = {WIDTH{1'b1}};
         sh_rotate_s = SR_SHIFT;
         sh_right_s  = LR_RIGHT;
      end else begin
         sh_data_s   = opnd_q;
         sh_rotate_s = ((op_q == OP_ROL) || (op_q == OP_ROR)) ? SR_ROTATE : SR_SHIFT;
         sh_right_s  = ((op_q == OP_SRL) || (op_q == OP_SRA) || (op_q == OP_ROR))
                       ? LR_RIGHT : LR_LEFT;
      end
   end

   shift_pipe_barrel_shifter #(
      .WIDTH      (WIDTH),
      .SHFT_WIDTH (SHFT_WIDTH)
   ) u_barrel_shifter (
      .data_i         (sh_data_s),
      .amt_i          (amt_q),
      .shift_rotate_i (sh_rotate_s),
      .left_right_i   (sh_right_s),
      .data_o         (sh_out_s)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      opnd_d   = opnd_q;
      amt_d    = amt_q;
      op_d     = op_q;
      result_d = result_q;
      err_d    = err_q;

      if (accept_s) begin
         opnd_d = in_data;
         amt_d  = in_amt;
         op_d   = in_op;
      end else begin
         opnd_d = opnd_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (!op_is_legal(op_q)) begin
               // Illegal opcode: pass the operand through and flag it.
               result_d = opnd_q;
               err_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               // SRA leaves the logical right shift here; MASK fills the sign.
               result_d = sh_out_s;
               err_d    = 1'b0;
               state_d  = (op_q == OP_SRA) ? ST_MASK : ST_DONE;
            end
         end
         ST_MASK: begin
            // ~mask has ones exactly in the vacated top bit positions.
            if (opnd_q[WIDTH-1]) begin
               result_d = result_q | ~sh_out_s;
            end else begin
               result_d = result_q;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready && in_valid) begin
               state_d = ST_EXEC;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         opnd_q   <= {WIDTH{1'b0}};
         amt_q    <= {SHFT_WIDTH{1'b0}};
         op_q     <= 3'd0;
         result_q <= {WIDTH{1'b0}};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opnd_q   <= opnd_d;
         amt_q    <= amt_d;
         op_q     <= op_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

endmodule : shift_pipe

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
// Purpose : Self-checking bench for shift_pipe at WIDTH=8. A behavioural
//           model computes every result arithmetically and tracks when a
//           result must be visible; a compare process checks the DUT against
//           it each cycle. Directed vectors carry hand-computed results.
// Ports   : none
// -----------------------------------------------------------------------------
module tb_shift_pipe;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [SW-1:0] in_amt;
   logic [2:0]    in_op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_err;

   int total = 0;
   int bad   = 0;

   // Hand-computed {err,data} results expected in order of delivery.
   logic [8:0] lit_q[$];

   // Model state.
   bit         live    = 1'b0;
   bit         m_busy  = 1'b0;
   bit         m_pend  = 1'b0;
   bit         m_valid = 1'b0;
   bit         m_zero  = 1'b0;
   int         m_wait  = 0;
   logic [8:0] m_pres  = 9'd0;
   logic [8:0] m_res   = 9'd0;

   always #5 clk = ~clk;

   shift_pipe #(
      .WIDTH      (W),
      .SHFT_WIDTH (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result {err,data} from the operation definitions.
   function automatic logic [8:0] model_op(input logic [2:0] op, input logic [7:0] d,
                                           input int a);
      logic [7:0] r;
      logic       e;
      r = d;
      e = 1'b0;
      case (op)
         3'd0: r = d << a;
         3'd1: r = d >> a;
         3'd2: r = 8'($signed(d) >>> a);
         3'd3: for (int i = 0; i < W; i++) r[(i + a) % W] = d[i];
         3'd4: for (int i = 0; i < W; i++) r[i] = d[(i + a) % W];
         default: begin
            r = d;
            e = 1'b1;
         end
      endcase
      return {e, r};
   endfunction

   // Per-cycle compare against the model, then advance the model.
   initial begin
      bit         exp_ir;
      bit         old_valid;
      logic [8:0] lit;
      forever begin
         @(negedge clk);
         exp_ir = !m_busy || (m_valid && out_ready);
         if (live) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
               chk("out_data", 32'(out_data), 32'(m_res[7:0]));
               chk("out_err", 32'(out_err), 32'(m_res[8]));
            end
            if (m_zero) begin
               chk("reset_outputs", 32'({out_err, out_data}), 32'h0);
            end
            if (m_valid && out_ready && !rst) begin
               if (lit_q.size() > 0) begin
                  lit = lit_q.pop_front();
                  chk("directed_result", 32'({out_err, out_data}), 32'(lit));
               end
            end
         end
         if (rst) begin
            live    = 1'b1;
            m_busy  = 1'b0;
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_zero  = 1'b1;
         end else if (live) begin
            old_valid = m_valid;
            if (m_pend) begin
               m_wait--;
               if (m_wait == 0) begin
                  m_pend  = 1'b0;
                  m_valid = 1'b1;
                  m_res   = m_pres;
                  m_zero  = 1'b0;
               end
            end
            if (old_valid && out_ready) begin
               m_valid = 1'b0;
               m_busy  = 1'b0;
            end
            if (in_valid && exp_ir) begin
               m_busy = 1'b1;
               m_pend = 1'b1;
               m_pres = model_op(in_op, in_data, int'(in_amt));
               // Result visible two samples after accept, three for SRA.
               m_wait = (in_op == 3'd2) ? 2 : 1;
            end
         end
      end
   end

   // Offer one command and hold it until accepted.
   task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a,
                       input bit push, input logic [8:0] lit);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      if (push) lit_q.push_back(lit);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_amt   = a;
      while (!done && n < 50) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("accept_timeout", 32'(done), 32'h1);
   endtask

   // Send a command and count samples from accept until out_valid.
   task automatic lat_check(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a,
                            input logic [8:0] lit, input int exp_lat);
      int n;
      bit seen;
      send(op, d, a, 1'b1, lit);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1'b1;
      end
      chk("latency", 32'(n), 32'(exp_lat));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_amt    = 3'd0;
      in_op     = 3'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Pin the model against hand-computed values.
      chk("model_sra_neg", 32'(model_op(3'd2, 8'h90, 2)), 32'h0E4);
      chk("model_rol",     32'(model_op(3'd3, 8'h81, 3)), 32'h00C);
      chk("model_ror",     32'(model_op(3'd4, 8'h01, 1)), 32'h080);
      chk("model_illegal", 32'(model_op(3'd6, 8'h5A, 0)), 32'h15A);

      // Latency and first results.
      lat_check(3'd0, 8'h81, 3'd1, 9'h002, 2);
      lat_check(3'd2, 8'h90, 3'd2, 9'h0E4, 3);

      // Back-to-back directed vectors (accepted in DONE as results leave).
      send(3'd2, 8'h50, 3'd2, 1'b1, 9'h014);
      send(3'd2, 8'h80, 3'd0, 1'b1, 9'h080);
      send(3'd4, 8'h01, 3'd1, 1'b1, 9'h080);
      send(3'd3, 8'h81, 3'd3, 1'b1, 9'h00C);
      send(3'd1, 8'hF0, 3'd7, 1'b1, 9'h001);
      send(3'd6, 8'h5A, 3'd2, 1'b1, 9'h15A);
      send(3'd0, 8'h0F, 3'd4, 1'b1, 9'h0F0);
      send(3'd3, 8'hA5, 3'd0, 1'b1, 9'h0A5);
      send(3'd4, 8'hA5, 3'd0, 1'b1, 9'h0A5);
      repeat (5) @(posedge clk);
      #1;

      // Back-pressure: result must hold while a new command waits.
      out_ready = 1'b0;
      send(3'd0, 8'h33, 3'd2, 1'b1, 9'h0CC);
      lit_q.push_back(9'h0F0);
      in_valid = 1'b1;
      in_op    = 3'd4;
      in_data  = 8'h0F;
      in_amt   = 3'd4;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_in_ready", 32'(in_ready), 32'h0);
         chk("hold_out_data", 32'(out_data), 32'h0CC);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("same_cycle_accept", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Reset during MASK of an SRA discards the command.
      send(3'd2, 8'hF0, 3'd3, 1'b0, 9'h000);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h1);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_out_err",   32'(out_err),   32'h0);
      repeat (4) @(posedge clk);
      #1;

      // Sweep every opcode against the model.
      for (int op = 0; op < 8; op++) begin
         send(3'(op), 8'hC3, 3'(op + 1), 1'b0, 9'h000);
         send(3'(op), 8'h3C, 3'(7 - op), 1'b0, 9'h000);
      end
      repeat (6) @(posedge clk);
      #1;
      chk("directed_all_delivered", 32'(lit_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_shift_pipe
